// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the split-transaction bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GRANT_M1 = 2'b01,
    GRANT_M2 = 2'b10
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M1   = 2'b01;
  localparam logic [1:0] GNT_M2   = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts grant cycles from 0 and flags the last allowed cycle.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // Counter restarts while the bus is idle and advances on every grant cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_split_arbiter.sv
// Two-master non-preemptive bus arbiter with split-transaction parking and a
// grant watchdog. Optional macro BUS_ARB_ROUND_ROBIN_EN replaces fixed M1
// priority between two fresh requests with least-recently-granted selection.
module bus_split_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic [1:0] m1_slave_sel,
  input  logic [1:0] m2_slave_sel,
  input  logic       m1_done,
  input  logic       m2_done,
  input  logic       s_split,
  input  logic       split_resume,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       arbiter_busy,
  output logic [1:0] bus_grant,
  output logic [1:0] slave_sel,
  output logic       split_pending,
  output logic       timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       pend_q, pend_d;
  logic       sown_q, sown_d;     // parked master: 0 = M1, 1 = M2
  logic [1:0] sslave_q, sslave_d;
  logic       res_q, res_d;
  logic       to_q, to_d;
  logic       expire;

  logic       m1_elig, m2_elig, pick_m1;
  logic       cur_m2, cur_done, cur_req, owns_split;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic       last_q, last_d;     // last granted master: 0 = M1, 1 = M2
`endif

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (state_q == IDLE),
    .enable (state_q != IDLE),
    .expire (expire)
  );

  // Next-state selection: grant choice in IDLE, exit handling while granted.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pend_d   = pend_q;
    sown_d   = sown_q;
    sslave_d = sslave_q;
    res_d    = res_q;
    to_d     = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif

    m1_elig = m1_request && !(pend_q && (!sown_q || (m1_slave_sel == sslave_q)));
    m2_elig = m2_request && !(pend_q && ( sown_q || (m2_slave_sel == sslave_q)));
`ifdef BUS_ARB_ROUND_ROBIN_EN
    pick_m1 = m1_elig && (!m2_elig || last_q);
`else
    pick_m1 = m1_elig;
`endif

    cur_m2     = (state_q == GRANT_M2);
    cur_done   = cur_m2 ? m2_done : m1_done;
    cur_req    = cur_m2 ? m2_request : m1_request;
    owns_split = pend_q && (sown_q == cur_m2);

    if (pend_q && split_resume) begin
      res_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_q && res_q) begin
          state_d = sown_q ? GRANT_M2 : GRANT_M1;
          sel_d   = sslave_q;
          res_d   = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          last_d  = sown_q;
`endif
        end else if (pick_m1) begin
          state_d = GRANT_M1;
          sel_d   = m1_slave_sel;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          last_d  = 1'b0;
`endif
        end else if (m2_elig) begin
          state_d = GRANT_M2;
          sel_d   = m2_slave_sel;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          last_d  = 1'b1;
`endif
        end
      end
      GRANT_M1, GRANT_M2: begin
        if (cur_done || !cur_req) begin
          state_d = IDLE;
          sel_d   = 2'b00;
          if (owns_split) pend_d = 1'b0;
        end else if (s_split && !pend_q) begin
          state_d  = IDLE;
          sel_d    = 2'b00;
          pend_d   = 1'b1;
          sown_d   = cur_m2;
          sslave_d = sel_q;
        end else if (expire) begin
          state_d = IDLE;
          sel_d   = 2'b00;
          to_d    = 1'b1;
          if (owns_split) pend_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'b00;
      end
    endcase

    if (!pend_d) res_d = 1'b0;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      pend_q   <= 1'b0;
      sown_q   <= 1'b0;
      sslave_q <= '0;
      res_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pend_q   <= pend_d;
      sown_q   <= sown_d;
      sslave_q <= sslave_d;
      res_q    <= res_d;
      to_q     <= to_d;
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Last-granted tracker; resets to M2 so M1 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign m1_grant      = (state_q == GRANT_M1);
  assign m2_grant      = (state_q == GRANT_M2);
  assign arbiter_busy  = (state_q != IDLE);
  assign bus_grant     = (state_q == GRANT_M1) ? GNT_M1 :
                         (state_q == GRANT_M2) ? GNT_M2 : GNT_NONE;
  assign slave_sel     = sel_q;
  assign split_pending = pend_q;
  assign timeout       = to_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Self-checking bench for bus_split_arbiter (watchdog shortened to 8 cycles).
module tb_bus_split_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       m1_request = 1'b0, m2_request = 1'b0;
  logic [1:0] m1_slave_sel = 2'd0, m2_slave_sel = 2'd0;
  logic       m1_done = 1'b0, m2_done = 1'b0;
  logic       s_split = 1'b0, split_resume = 1'b0;
  logic       m1_grant, m2_grant, arbiter_busy, split_pending, timeout;
  logic [1:0] bus_grant, slave_sel;

  int checks = 0;
  int errors = 0;

  bus_split_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .m1_request(m1_request), .m2_request(m2_request),
    .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
    .m1_done(m1_done), .m2_done(m2_done),
    .s_split(s_split), .split_resume(split_resume),
    .m1_grant(m1_grant), .m2_grant(m2_grant), .arbiter_busy(arbiter_busy),
    .bus_grant(bus_grant), .slave_sel(slave_sel),
    .split_pending(split_pending), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (0 none, 1 M1, 2 M2), cycles held so far, split record.
  int mo = 0, msel = 0, mpend = 0, msown = 0, msslave = 0, mres = 0;
  int mage = 0, mto = 0, mlast = 2;

  always @(posedge clk or negedge rstn) begin : model
    int no, nsel, npend, nsown, nsslave, nres, nage, nto, nlast;
    bit e1, e2, req, dn;
    if (!rstn) begin
      mo = 0; msel = 0; mpend = 0; msown = 0; msslave = 0;
      mres = 0; mage = 0; mto = 0; mlast = 2;
    end else begin
      no = mo; nsel = msel; npend = mpend; nsown = msown; nsslave = msslave;
      nres = mres; nage = mage; nto = 0; nlast = mlast;
      if (mpend != 0 && split_resume) nres = 1;
      if (mo == 0) begin
        e1 = m1_request && !(mpend != 0 && (msown == 1 || int'(m1_slave_sel) == msslave));
        e2 = m2_request && !(mpend != 0 && (msown == 2 || int'(m2_slave_sel) == msslave));
        nage = 1;
        if (mpend != 0 && mres != 0) begin
          no = msown; nsel = msslave; nres = 0;
        end else if (e1 && e2) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
          no = (mlast == 1) ? 2 : 1;
`else
          no = 1;
`endif
        end else if (e1) no = 1;
        else if (e2) no = 2;
        if (no != 0 && !(mpend != 0 && mres != 0))
          nsel = (no == 1) ? int'(m1_slave_sel) : int'(m2_slave_sel);
        if (no != 0) nlast = no;
      end else begin
        req = (mo == 1) ? m1_request : m2_request;
        dn  = (mo == 1) ? m1_done : m2_done;
        if (dn || !req) begin
          no = 0; nsel = 0;
          if (mpend != 0 && msown == mo) npend = 0;
        end else if (s_split && mpend == 0) begin
          no = 0; nsel = 0; npend = 1; nsown = mo; nsslave = msel;
        end else if (mage == TO) begin
          no = 0; nsel = 0; nto = 1;
          if (mpend != 0 && msown == mo) npend = 0;
        end else begin
          nage = mage + 1;
        end
      end
      if (npend == 0) nres = 0;
      mo = no; msel = nsel; mpend = npend; msown = nsown; msslave = nsslave;
      mres = nres; mage = nage; mto = nto; mlast = nlast;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("m1_grant", {7'd0, m1_grant}, (mo == 1) ? 8'd1 : 8'd0);
    chk("m2_grant", {7'd0, m2_grant}, (mo == 2) ? 8'd1 : 8'd0);
    chk("busy", {7'd0, arbiter_busy}, (mo != 0) ? 8'd1 : 8'd0);
    chk("bus_grant", {6'd0, bus_grant}, 8'(mo));
    chk("slave_sel", {6'd0, slave_sel}, 8'(msel));
    chk("split_pending", {7'd0, split_pending}, 8'(mpend));
    chk("timeout", {7'd0, timeout}, 8'(mto));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : guard
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin : stim
    int cnt;
    step(); step();
    rstn = 1'b1;
    step();
    chk("idle_after_reset", {6'd0, bus_grant}, 8'd0);

    // Reset mid-grant of M2.
    m2_request = 1'b1; m2_slave_sel = 2'd1;
    step();
    chk("m2_granted", {6'd0, bus_grant}, 8'd2);
    step();
    rstn = 1'b0;
    #1;
    chk("async_reset_grant", {6'd0, bus_grant}, 8'd0);
    chk("async_reset_busy", {7'd0, arbiter_busy}, 8'd0);
    chk("async_reset_sel", {6'd0, slave_sel}, 8'd0);
    m2_request = 1'b0; m1_request = 1'b1;
    rstn = 1'b1;
    step();
    chk("post_reset_m1", {6'd0, bus_grant}, 8'd1);
    m1_request = 1'b0;
    step();

    // Simultaneous requests, fresh reset so round-robin also favours M1.
    rstn = 1'b0; #1; rstn = 1'b1;
    m1_request = 1'b1; m1_slave_sel = 2'd2;
    m2_request = 1'b1; m2_slave_sel = 2'd1;
    step();
    chk("both_first", {6'd0, bus_grant}, 8'd1);
    chk("both_first_sel", {6'd0, slave_sel}, 8'd2);
    m1_done = 1'b1; m1_request = 1'b0;
    step();
    m1_done = 1'b0;
    chk("turnaround", {6'd0, bus_grant}, 8'd0);
    step();
    chk("both_second", {6'd0, bus_grant}, 8'd2);
    chk("both_second_sel", {6'd0, slave_sel}, 8'd1);
    m2_done = 1'b1; m2_request = 1'b0;
    step();
    m2_done = 1'b0;
    m1_request = 1'b1; m2_request = 1'b1;
    step(); step();
    chk("tie_after_m2", {6'd0, bus_grant}, 8'd1);
    m1_done = 1'b1;
    step();
    m1_done = 1'b0;
    step();
`ifdef BUS_ARB_ROUND_ROBIN_EN
    chk("tie_repeat", {6'd0, bus_grant}, 8'd2);
`else
    chk("tie_repeat", {6'd0, bus_grant}, 8'd1);
`endif
    m1_request = 1'b0; m2_request = 1'b0;
    step(); step();

    // Non-preemption.
    m2_request = 1'b1;
    step();
    chk("np_m2", {6'd0, bus_grant}, 8'd2);
    m1_request = 1'b1;
    step(); step();
    chk("np_hold", {6'd0, bus_grant}, 8'd2);
    m2_done = 1'b1; m2_request = 1'b0;
    step();
    m2_done = 1'b0;
    chk("np_idle", {6'd0, bus_grant}, 8'd0);
    step();
    chk("np_m1", {6'd0, bus_grant}, 8'd1);
    m1_request = 1'b0;
    step();

    // Split on slave 3.
    m1_request = 1'b1; m1_slave_sel = 2'd3;
    step();
    chk("sp_m1_sel", {6'd0, slave_sel}, 8'd3);
    s_split = 1'b1;
    step();
    s_split = 1'b0;
    chk("sp_pending", {7'd0, split_pending}, 8'd1);
    step();
    chk("sp_m1_ignored", {6'd0, bus_grant}, 8'd0);
    m2_request = 1'b1; m2_slave_sel = 2'd3;
    step(); step();
    chk("sp_m2_stall", {6'd0, bus_grant}, 8'd0);
    m2_slave_sel = 2'd1;
    step();
    chk("sp_m2_other", {6'd0, bus_grant}, 8'd2);
    split_resume = 1'b1;
    step();
    split_resume = 1'b0;
    chk("sp_m2_keeps", {6'd0, bus_grant}, 8'd2);
    m2_done = 1'b1; m2_request = 1'b0;
    step();
    m2_done = 1'b0;
    step();
    chk("sp_resumed", {6'd0, bus_grant}, 8'd1);
    chk("sp_resumed_sel", {6'd0, slave_sel}, 8'd3);
    m1_done = 1'b1; m1_request = 1'b0;
    step();
    m1_done = 1'b0;
    chk("sp_cleared", {7'd0, split_pending}, 8'd0);
    m1_slave_sel = 2'd0;
    s_split = 1'b1;
    step();
    s_split = 1'b0;
    chk("sp_idle_ignored", {7'd0, split_pending}, 8'd0);

    // Watchdog.
    m1_request = 1'b1;
    step();
    cnt = 0;
    while (m1_grant && cnt < 20) begin
      cnt++;
      step();
    end
    chk("wd_grant_len", 8'(cnt), 8'(TO));
    chk("wd_timeout", {7'd0, timeout}, 8'd1);
    chk("wd_busy", {7'd0, arbiter_busy}, 8'd0);
    step();
    chk("wd_pulse_end", {7'd0, timeout}, 8'd0);
    m1_request = 1'b0;
    step(); step();

    // Done and split together: done wins.
    m1_request = 1'b1; m1_slave_sel = 2'd2;
    step();
    m1_done = 1'b1; s_split = 1'b1;
    step();
    m1_done = 1'b0; s_split = 1'b0;
    chk("ds_no_split", {7'd0, split_pending}, 8'd0);
    step();
    chk("ds_regrant", {6'd0, bus_grant}, 8'd1);
    m1_request = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_split_arbiter.md
Name: bus_split_arbiter

Overview:
- Two-master, non-preemptive system-bus arbiter with split-transaction support and a grant watchdog.
- Sits between masters M1/M2 and the slave address decoder; drives bus_grant and slave_sel to the bus mux.
- A slow slave may split: the arbiter parks that master, lends the bus to the other master, and re-grants the parked master when the slave signals resume.
- Grants are held until the owning master signals done; fixed M1 priority applies only at grant time.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a grant may be held before forced release.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): watchdog counter width; derived, do not override.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- m1_request, m2_request  in  1  master bus request (level).
- m1_slave_sel, m2_slave_sel  in  2  target slave of each master.
- m1_done, m2_done  in  1  one-cycle pulse: owning master's transaction complete.
- s_split  in  1  addressed slave splits the current transaction.
- split_resume  in  1  pulse: split slave ready to complete.
- m1_grant, m2_grant  out  1  registered grant per master.
- arbiter_busy  out  1  high in any GRANT state.
- bus_grant  out  2  00 none, 01 M1, 10 M2.
- slave_sel  out  2  slave of current owner; 00 when idle.
- split_pending  out  1  a master is parked on a split.
- timeout  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (rstn low, async): all outputs 0; state IDLE; split owner, split slave, resume flag and counter cleared. Reset mid-grant drops the grant immediately; the parked split is discarded.
- States: IDLE, GRANT_M1, GRANT_M2.
- IDLE candidates, in priority order:
  (a) parked master, if split_pending and resume flag set;
  (b) M1 request;
  (c) M2 request.
- A parked master's own request is ignored until resume.
- A request targeting the split slave while split_pending is not eligible and stalls.
- Chosen master goes to GRANT_Mx on the next edge. Latency: request sampled at edge k gives grant, bus_grant, slave_sel and busy valid after edge k.
- slave_sel is latched at grant and held constant for the whole grant. A resumed master gets the recorded split slave.
- GRANT_Mx exits to IDLE on the next edge when any of these holds:
  - mx_done;
  - mx_request deasserts;
  - s_split;
  - watchdog expiry.
- Exit priority: done > request drop > split > timeout.
- IDLE is always held at least one cycle (turnaround). Done in cycle n: grant low after edge n, earliest new grant after edge n+1.
- No preemption: M1 request never interrupts a GRANT_M2.
- Split: on exit by s_split, record split owner = x and split slave = slave_sel, and set split_pending. Clear resume flag on re-grant of the owner; clear split_pending when that re-grant ends by done or request drop.
- s_split while split_pending (other master) is ignored; the transaction continues.
- s_split while IDLE is ignored.
- split_resume latches the resume flag only while split_pending; otherwise ignored.
- Watchdog: counter is 0 in the first grant cycle and increments each GRANT cycle. When it reaches TIMEOUT_CYCLES-1 without another exit, leave on the next edge and pulse timeout in the following IDLE cycle. A grant therefore lasts at most TIMEOUT_CYCLES cycles.
- A timed-out resumed master drops its split (split_pending cleared).

Optional Feature:
- Macro: BUS_ARB_ROUND_ROBIN_EN.
- Defined: in IDLE with both fresh M1 and M2 requests eligible, grant the master not granted most recently. The last-granted register resets to M2, so M1 wins first. Split-resume still has top priority.
- Undefined: fixed M1 > M2 priority; last-granted register absent.

Decomposition:
- Package bus_arb_pkg:
  - state enum (IDLE/GRANT_M1/GRANT_M2);
  - bus_grant codes GNT_NONE=2'b00, GNT_M1=2'b01, GNT_M2=2'b10;
  - default TIMEOUT_CYCLES.
- One sub-module: arb_watchdog (clear, enable, CNT_W counter, expire output).

Test Plan:
- Reset: rstn low mid-GRANT_M2 -> all outputs 0 asynchronously; after release with m1_request high, bus_grant=01 one edge later.
- Both request, m1_slave_sel=2, m2_slave_sel=1 -> bus_grant=01, slave_sel=10; m1_done -> 1 idle cycle -> bus_grant=10, slave_sel=01. With BUS_ARB_ROUND_ROBIN_EN, a second simultaneous round grants M2 first.
- Non-preemption: M2 granted, M1 requests -> bus_grant stays 10 until m2_done; then 1 idle cycle; then 01.
- Split on slave 3:
  - M1 on slave 3 asserts s_split -> split_pending=1, M1 ignored.
  - M2 requesting slave 3 stalls; M2 requesting slave 1 is granted.
  - split_resume during M2's grant; M2 done -> M1 regranted with slave_sel=11.
  - m1_done -> split_pending=0.
- Watchdog with TIMEOUT_CYCLES=8: M1 holds request with no done -> grant high exactly 8 cycles, then timeout pulses 1 cycle, busy=0.
- Simultaneous m1_done and s_split -> treated as done: split_pending stays 0.
